stream_pkt_arb: RTL and testbench

Packet-granular round-robin arbiter that merges up to `nsrc` CoBuilder-style streams into one downstream stream. Sources are consumer-side stream interfaces (rdy/en/eos/data), typically the outputs of stream FIFOs feeding the PCA projection cores. The sink is a producer-side interface, typically the write port of a shared result FIFO. A grant is held from the first word of a packet through its eos word, so packets are never interleaved. A one-word output register breaks the combinational path between source and sink.

---
 rtl/stream_pkt_arb_pkg.sv | 21 ++
 rtl/stream_pkt_arb_rr_pick.sv | 50 +++++
 rtl/stream_pkt_arb.sv | 155 +++++++++++++++
 tb/tb_stream_pkt_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkt_arb_pkg
// Purpose  : Shared types and helpers for the packet-granular stream arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package stream_pkt_arb_pkg;

  // Arbiter FSM: IDLE selects a source, XFER holds the grant until eos.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Increment modulo n; works for non-power-of-two source counts.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_pkt_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkt_arb_rr_pick
// Purpose  : Combinational round-robin picker. Rotates the request vector so
//            that ptr lands on bit 0, priority-encodes the lowest set bit and
//            adds ptr back modulo nsrc.
// Revision : 1.0 - initial release
// ============================================================================
module stream_pkt_arb_rr_pick #(
  parameter int nsrc     = 4,
  parameter int selwidth = 2
) (
  input  logic [nsrc-1:0]     req,
  input  logic [selwidth-1:0] ptr,
  output logic                any,
  output logic [selwidth-1:0] pick
);

  localparam logic [selwidth:0] c_nsrc = (selwidth+1)'(nsrc);

  logic [nsrc-1:0]     rot;
  logic [selwidth-1:0] off;
  logic [selwidth:0]   sum;

  // Rotate right by ptr: rot[i] = req[(ptr + i) mod nsrc] (ptr < nsrc).
  assign rot = nsrc'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the first candidate after ptr.
  always_comb begin
    any = 1'b0;
    off = '0;
    for (int i = nsrc - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        off = selwidth'(i);
      end
    end
  end

  // Undo the rotation: pick = (ptr + off) mod nsrc, one conditional subtract.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= c_nsrc) begin
      sum = sum - c_nsrc;
    end
    pick = sum[selwidth-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/stream_pkt_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkt_arb
// Purpose  : Merges nsrc rdy/en/eos/data streams into one sink. Grants are
//            held for a whole packet (first word through eos) and rotate
//            round-robin between packets. A one-word output register sits
//            between the sources and the sink.
// Revision : 1.0 - initial release
// ============================================================================
module stream_pkt_arb
  import stream_pkt_arb_pkg::*;
#(
  parameter int datawidth = 8,
  parameter int nsrc      = 4,
  parameter int selwidth  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [nsrc-1:0]           src_rdy,
  output logic [nsrc-1:0]           src_en,
  input  logic [nsrc-1:0]           src_eos,
  input  logic [nsrc*datawidth-1:0] src_data,
  input  logic [nsrc-1:0]           src_mask,
  input  logic                      dst_rdy,
  output logic                      dst_en,
  output logic                      dst_eos,
  output logic [datawidth-1:0]      dst_data,
  output logic [selwidth-1:0]       dst_src,
  output logic                      busy
);

  arb_state_e           state_q, state_d;
  logic [selwidth-1:0]  grant_q, grant_d;
  logic [selwidth-1:0]  ptr_q,   ptr_d;
  logic                 ovalid_q, ovalid_d;
  logic                 oeos_q,  oeos_d;
  logic [datawidth-1:0] odata_q, odata_d;
  logic [selwidth-1:0]  osrc_q,  osrc_d;

  logic [nsrc-1:0]      req;
  logic                 req_any;
  logic [selwidth-1:0]  req_pick;
  logic                 g_rdy;
  logic                 g_eos;
  logic [datawidth-1:0] g_data;
  logic                 take;
  logic                 out_fire;

  // Masked sources are skipped only when choosing a new packet.
  assign req = src_rdy & src_mask;

  stream_pkt_arb_rr_pick #(
    .nsrc     (nsrc),
    .selwidth (selwidth)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .any  (req_any),
    .pick (req_pick)
  );

  // Select the granted source's rdy/eos/data.
  always_comb begin
    g_rdy  = 1'b0;
    g_eos  = 1'b0;
    g_data = '0;
    for (int i = 0; i < nsrc; i++) begin
      if (grant_q == selwidth'(i)) begin
        g_rdy  = src_rdy[i];
        g_eos  = src_eos[i];
        g_data = src_data[i*datawidth +: datawidth];
      end
    end
  end

  // A word moves when granted source has data and the output register is
  // empty or draining this cycle.
  assign take     = (state_q == ARB_XFER) && g_rdy && (!ovalid_q || dst_rdy);
  assign out_fire = ovalid_q && dst_rdy;

  // One-hot consume strobe toward the granted source.
  always_comb begin
    src_en = '0;
    for (int i = 0; i < nsrc; i++) begin
      if (take && (grant_q == selwidth'(i))) begin
        src_en[i] = 1'b1;
      end
    end
  end

  // Next-state: grant selection, packet completion, output register load.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    ovalid_d = ovalid_q;
    oeos_d   = oeos_q;
    odata_d  = odata_q;
    osrc_d   = osrc_q;

    case (state_q)
      ARB_IDLE: begin
        if (req_any) begin
          grant_d = req_pick;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (take && g_eos) begin
          state_d = ARB_IDLE;
          ptr_d   = selwidth'(wrap_inc(int'(grant_q), nsrc));
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (take) begin
      ovalid_d = 1'b1;
      oeos_d   = g_eos;
      odata_d  = g_data;
      osrc_d   = grant_q;
    end else if (out_fire) begin
      ovalid_d = 1'b0;
    end
  end

  // State and output register, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      ovalid_q <= 1'b0;
      oeos_q   <= 1'b0;
      odata_q  <= '0;
      osrc_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      ovalid_q <= ovalid_d;
      oeos_q   <= oeos_d;
      odata_q  <= odata_d;
      osrc_q   <= osrc_d;
    end
  end

  assign dst_en   = out_fire;
  assign dst_eos  = oeos_q && ovalid_q;
  assign dst_data = odata_q;
  assign dst_src  = osrc_q;
  assign busy     = (state_q == ARB_XFER);

endmodule
`default_nettype wire

// File: tb/tb_stream_pkt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_pkt_arb
// Purpose  : Directed self-checking bench for stream_pkt_arb (4 x 8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_pkt_arb;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   src_rdy, src_en, src_eos, src_mask;
  logic [NS*DW-1:0] src_data;
  logic            dst_rdy, dst_en, dst_eos, busy;
  logic [DW-1:0]   dst_data;
  logic [SW-1:0]   dst_src;

  always #5 clk = ~clk;

  stream_pkt_arb #(.datawidth(DW), .nsrc(NS), .selwidth(SW)) dut (
    .clk(clk), .reset(reset),
    .src_rdy(src_rdy), .src_en(src_en), .src_eos(src_eos),
    .src_data(src_data), .src_mask(src_mask),
    .dst_rdy(dst_rdy), .dst_en(dst_en), .dst_eos(dst_eos),
    .dst_data(dst_data), .dst_src(dst_src), .busy(busy)
  );

  // Source queues {eos, data}, output log {src, eos, data}
  logic [8:0]  mem [NS][32];
  int          hd [NS];
  int          tl [NS];
  logic [3:0]  stall;
  logic [10:0] olog [64];
  int          ocyc [64];
  int          on, cyc, bp_bad;
  logic        ov_m, den_s, bsy_s;
  logic [3:0]  en_s;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic push(input int s, input logic [7:0] d, input logic e);
    mem[s][tl[s]] = {e, d};
    tl[s]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      logic [8:0] h;
      h = (hd[i] != tl[i]) ? mem[i][hd[i]] : 9'h0;
      src_rdy[i] = (hd[i] != tl[i]) && !stall[i];
      src_eos[i] = h[8];
      src_data[i*DW +: DW] = h[7:0];
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    en_s  = src_en;
    den_s = dst_en;
    bsy_s = busy;
    if (dst_en && on < 64) begin
      olog[on] = {dst_src, dst_eos, dst_data};
      ocyc[on] = cyc;
      on++;
    end
    if (ov_m && !dst_rdy && src_en != 4'b0) bp_bad++;
    @(posedge clk);
    #1;
    if (reset) ov_m = 1'b0;
    else begin
      ov_m = (en_s != 4'b0) || (ov_m && !den_s);
      for (int i = 0; i < NS; i++) if (en_s[i]) hd[i]++;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 4'b0; src_mask = 4'hF; dst_rdy = 1'b1;
    for (int i = 0; i < NS; i++) begin hd[i] = 0; tl[i] = 0; end
    run(2);
    reset = 1'b0; on = 0; bp_bad = 0; ov_m = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    for (int i = 0; i < NS; i++) push(i, 8'hF0 + 8'(i), 1'b1);
    run(2);
    drive();
    @(negedge clk);
    n_checks++; if (src_en !== 4'b0) $display("FAIL rst_src_en: got %b want 0000", src_en); else n_pass++;
    n_checks++; if (dst_en !== 1'b0) $display("FAIL rst_dst_en: got %b want 0", dst_en); else n_pass++;
    n_checks++; if (dst_eos !== 1'b0) $display("FAIL rst_dst_eos: got %b want 0", dst_eos); else n_pass++;
    n_checks++; if (dst_data !== 8'h00) $display("FAIL rst_dst_data: got %h want 00", dst_data); else n_pass++;
    n_checks++; if (dst_src !== 2'd0) $display("FAIL rst_dst_src: got %0d want 0", dst_src); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single_packet();
    logic [10:0] exp [3];
    exp[0] = {2'd2, 1'b0, 8'h11};
    exp[1] = {2'd2, 1'b0, 8'h22};
    exp[2] = {2'd2, 1'b1, 8'h33};
    do_reset();
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    run(8);
    n_checks++; if (on != 3) $display("FAIL single_count: got %0d want 3", on); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (olog[k] !== exp[k]) $display("FAIL single_word%0d: got %h want %h", k, olog[k], exp[k]); else n_pass++;
    end
    for (int k = 1; k < 3; k++) begin
      n_checks++; if (ocyc[k] - ocyc[k-1] != 1) $display("FAIL single_gap%0d: got %0d want 1", k, ocyc[k] - ocyc[k-1]); else n_pass++;
    end
    // ptr now 3: source 3 must win over source 0
    on = 0;
    push(0, 8'hA0, 1'b1); push(3, 8'hB0, 1'b1);
    run(10);
    n_checks++; if (olog[0] !== {2'd3, 1'b1, 8'hB0}) $display("FAIL single_ptr3_first: got %h want %h", olog[0], {2'd3, 1'b1, 8'hB0}); else n_pass++;
    n_checks++; if (olog[1] !== {2'd0, 1'b1, 8'hA0}) $display("FAIL single_ptr3_second: got %h want %h", olog[1], {2'd0, 1'b1, 8'hA0}); else n_pass++;
  endtask

  task automatic test_fairness();
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NS; i++) begin
        push(i, 8'((i << 4) | (p << 2)), 1'b0);
        push(i, 8'((i << 4) | (p << 2) | 1), 1'b1);
      end
    run(40);
    n_checks++; if (on != 16) $display("FAIL fair_count: got %0d want 16", on); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      int pk, s, p, w;
      logic [10:0] e;
      pk = k / 2; s = pk % 4; p = pk / 4; w = k % 2;
      e = {2'(s), 1'(w), 8'((s << 4) | (p << 2) | w)};
      n_checks++; if (olog[k] !== e) $display("FAIL fair_word%0d: got %h want %h", k, olog[k], e); else n_pass++;
    end
    for (int k = 1; k < 16; k++) begin
      int g;
      g = (k % 2 == 1) ? 1 : 2;
      n_checks++; if (ocyc[k] - ocyc[k-1] != g) $display("FAIL fair_gap%0d: got %0d want %0d", k, ocyc[k] - ocyc[k-1], g); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic pat [16] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,
                       1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
    do_reset();
    for (int w = 0; w < 4; w++) push(1, 8'h41 + 8'(w), w == 3);
    for (int c = 0; c < 16; c++) begin
      dst_rdy = pat[c];
      cycle();
    end
    dst_rdy = 1'b1;
    n_checks++; if (on != 4) $display("FAIL bp_count: got %0d want 4", on); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      logic [10:0] e;
      e = {2'd1, 1'(k == 3), 8'h41 + 8'(k)};
      n_checks++; if (olog[k] !== e) $display("FAIL bp_word%0d: got %h want %h", k, olog[k], e); else n_pass++;
    end
    n_checks++; if (bp_bad != 0) $display("FAIL bp_src_en_hold: got %0d bad cycles want 0", bp_bad); else n_pass++;
  endtask

  task automatic test_mask();
    logic [1:0] es [4] = '{2'd1, 2'd1, 2'd3, 2'd3};
    do_reset();
    src_mask = 4'b1010;
    for (int i = 0; i < NS; i++) begin
      push(i, 8'(i << 4), 1'b0);
      push(i, 8'((i << 4) | 1), 1'b1);
    end
    run(20);
    n_checks++; if (on != 4) $display("FAIL mask_count: got %0d want 4", on); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (olog[k][10:9] !== es[k]) $display("FAIL mask_src%0d: got %0d want %0d", k, olog[k][10:9], es[k]); else n_pass++;
    end
    n_checks++; if (hd[0] != 0 || hd[2] != 0) $display("FAIL mask_untouched: got hd0=%0d hd2=%0d want 0 0", hd[0], hd[2]); else n_pass++;
    // Mask cleared under an active packet: packet completes
    do_reset();
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b1);
    run(2);
    src_mask = 4'b1101;
    push(0, 8'h70, 1'b1);
    run(12);
    n_checks++; if (on != 4) $display("FAIL maskclr_count: got %0d want 4", on); else n_pass++;
    n_checks++; if (olog[2] !== {2'd1, 1'b1, 8'h63}) $display("FAIL maskclr_eos: got %h want %h", olog[2], {2'd1, 1'b1, 8'h63}); else n_pass++;
    n_checks++; if (olog[3] !== {2'd0, 1'b1, 8'h70}) $display("FAIL maskclr_next: got %h want %h", olog[3], {2'd0, 1'b1, 8'h70}); else n_pass++;
  endtask

  task automatic test_stall();
    int busy_bad, en_bad;
    logic [10:0] e [6];
    e[0] = {2'd0, 1'b0, 8'hC1}; e[1] = {2'd0, 1'b0, 8'hC2};
    e[2] = {2'd0, 1'b0, 8'hC3}; e[3] = {2'd0, 1'b1, 8'hC4};
    e[4] = {2'd1, 1'b0, 8'hD1}; e[5] = {2'd1, 1'b1, 8'hD2};
    do_reset();
    for (int w = 0; w < 4; w++) push(0, 8'hC1 + 8'(w), w == 3);
    push(1, 8'hD1, 1'b0); push(1, 8'hD2, 1'b1);
    run(3);
    stall[0] = 1'b1;
    busy_bad = 0; en_bad = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (!bsy_s) busy_bad++;
      if (en_s != 4'b0) en_bad++;
    end
    stall[0] = 1'b0;
    run(15);
    n_checks++; if (busy_bad != 0) $display("FAIL stall_busy: got %0d idle cycles want 0", busy_bad); else n_pass++;
    n_checks++; if (en_bad != 0) $display("FAIL stall_src_en: got %0d active cycles want 0", en_bad); else n_pass++;
    n_checks++; if (on != 6) $display("FAIL stall_count: got %0d want 6", on); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (olog[k] !== e[k]) $display("FAIL stall_word%0d: got %h want %h", k, olog[k], e[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(1, 8'h51, 1'b1);
    run(5);
    for (int w = 0; w < 4; w++) push(2, 8'hE1 + 8'(w), w == 3);
    run(2);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    on = 0;
    push(1, 8'h52, 1'b1);
    drive();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (src_en !== 4'b0) $display("FAIL rmid_src_en: got %b want 0000", src_en); else n_pass++;
    n_checks++; if (dst_en !== 1'b0) $display("FAIL rmid_dst_en: got %b want 0", dst_en); else n_pass++;
    n_checks++; if (dst_data !== 8'h00 || dst_src !== 2'd0 || dst_eos !== 1'b0)
      $display("FAIL rmid_oreg: got data=%h src=%0d eos=%b want 00 0 0", dst_data, dst_src, dst_eos); else n_pass++;
    @(posedge clk);
    #1;
    cyc++;
    run(14);
    n_checks++; if (on != 4) $display("FAIL rmid_count: got %0d want 4", on); else n_pass++;
    n_checks++; if (olog[0] !== {2'd1, 1'b1, 8'h52}) $display("FAIL rmid_ptr0: got %h want %h", olog[0], {2'd1, 1'b1, 8'h52}); else n_pass++;
    n_checks++; if (olog[1] !== {2'd2, 1'b0, 8'hE2}) $display("FAIL rmid_resume: got %h want %h", olog[1], {2'd2, 1'b0, 8'hE2}); else n_pass++;
    n_checks++; if (olog[3] !== {2'd2, 1'b1, 8'hE4}) $display("FAIL rmid_tail: got %h want %h", olog[3], {2'd2, 1'b1, 8'hE4}); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; dst_rdy = 1'b1; src_mask = 4'hF; stall = 4'b0;
    src_rdy = '0; src_eos = '0; src_data = '0;
    cyc = 0; on = 0; bp_bad = 0; ov_m = 1'b0;
    for (int i = 0; i < NS; i++) begin hd[i] = 0; tl[i] = 0; end
    test_reset();
    test_single_packet();
    test_fairness();
    test_backpressure();
    test_mask();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
